// File: rtl/conv_fft_scheduler_pkg.sv
// conv_fft_scheduler_pkg: shared conv layer types and default address widths
package conv_fft_scheduler_pkg;
    localparam int IMG_AW_DEF = 13;
    localparam int KER_AW_DEF = 9;
    typedef enum logic [2:0] {IDLE, WR_IMAGE, WR_KER0, WR_KER1, READ, FINISH} state_t;
endpackage

// File: rtl/addr_counter.sv
// addr_counter: saturating address counter with clear-on-load and terminal-count flag
module addr_counter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          enable,
    input  logic [AW:0]   limit,
    output logic [AW-1:0] count,
    output logic          tc
);
    // tc marks the last address; the counter holds there instead of wrapping
    assign tc = ({1'b0, count} + (AW+1)'(1)) == limit;
    always_ff @(posedge clk)
        if (reset || load) count <= '0;
        else if (enable && !tc) count <= count + AW'(1);
endmodule

// File: rtl/conv_fft_scheduler.sv
// conv_fft_scheduler: stores image/kernel FFT tiles into banked memories, then
// sweeps every kernel x image address pair for the multiply phase
module conv_fft_scheduler
    import conv_fft_scheduler_pkg::*;
#(
    parameter int IMG_AW = IMG_AW_DEF,
    parameter int KER_AW = KER_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IMG_AW:0]   image_count,
    input  logic [KER_AW:0]   kernel_count,
    input  logic              image_or_filter,
    input  logic              fft_next_out,
    output logic              image_we,
    output logic [IMG_AW-1:0] image_write_address,
    output logic [1:0]        kernel_we,
    output logic [KER_AW-1:0] kernel_write_address,
    output logic [IMG_AW-1:0] image_read_address,
    output logic [KER_AW-1:0] kernel_read_address,
    output logic              read_valid,
    output logic              busy,
    output logic              done,
    output logic              error
);
    state_t state, state_n, acc_st;
    logic [IMG_AW:0] img_cnt;
    logic [KER_AW:0] ker_cnt;
    logic go, img_zero, ker_zero, last_pend, accept, issue, rd_drain;
    logic img_wr_tc, ker_wr_tc, img_rd_tc, ker_rd_tc;

    assign go = state == IDLE && start;
    assign img_zero = img_cnt == '0;
    assign ker_zero = ker_cnt == '0;
    assign issue = state == READ && !rd_drain && !img_zero && !ker_zero;
    assign busy = state != IDLE;
    assign done = state == FINISH;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = WR_IMAGE;
            WR_IMAGE: if (img_zero || (image_we && img_wr_tc)) state_n = WR_KER0;
            WR_KER0:  if (ker_zero || (kernel_we[0] && ker_wr_tc)) state_n = WR_KER1;
            WR_KER1:  if (ker_zero || (kernel_we[1] && ker_wr_tc)) state_n = READ;
            READ:     if (rd_drain || img_zero || ker_zero) state_n = FINISH;
            FINISH:   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // A pulse arriving while a phase's final strobe is out belongs to the next phase
    assign last_pend = (image_we && img_wr_tc) || (|kernel_we && ker_wr_tc);
    assign acc_st = last_pend ? state_n : state;
    assign accept = fft_next_out &&
        ((acc_st == WR_IMAGE && !image_or_filter && !img_zero) ||
         ((acc_st == WR_KER0 || acc_st == WR_KER1) && image_or_filter && !ker_zero));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            img_cnt    <= '0;
            ker_cnt    <= '0;
            image_we   <= 1'b0;
            kernel_we  <= 2'b00;
            rd_drain   <= 1'b0;
            read_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= state_n;
            if (go) begin
                img_cnt <= image_count;
                ker_cnt <= kernel_count;
            end
            image_we   <= accept && acc_st == WR_IMAGE;
            kernel_we  <= {accept && acc_st == WR_KER1, accept && acc_st == WR_KER0};
            rd_drain   <= issue && img_rd_tc && ker_rd_tc;
            read_valid <= issue;
            error      <= error || (fft_next_out && !accept);
        end
    end

    addr_counter #(.AW(IMG_AW)) u_img_wr (
        .clk(clk), .reset(reset), .load(go), .enable(image_we),
        .limit(img_cnt), .count(image_write_address), .tc(img_wr_tc)
    );

    // Shared kernel write counter restarts at 0 for bank 1
    addr_counter #(.AW(KER_AW)) u_ker_wr (
        .clk(clk), .reset(reset), .load(go || (kernel_we[0] && ker_wr_tc)), .enable(|kernel_we),
        .limit(ker_cnt), .count(kernel_write_address), .tc(ker_wr_tc)
    );

    addr_counter #(.AW(IMG_AW)) u_img_rd (
        .clk(clk), .reset(reset), .load(go || (issue && img_rd_tc)), .enable(issue),
        .limit(img_cnt), .count(image_read_address), .tc(img_rd_tc)
    );

    addr_counter #(.AW(KER_AW)) u_ker_rd (
        .clk(clk), .reset(reset), .load(go), .enable(issue && img_rd_tc),
        .limit(ker_cnt), .count(kernel_read_address), .tc(ker_rd_tc)
    );
endmodule

// File: doc/conv_fft_scheduler.md
CONV_FFT_SCHEDULER -- requirements
Module: conv_fft_scheduler

Interface
REQ-001 The block SHALL have parameter IMG_AW, default 13, meaning image memory address width (8192 entries).
REQ-002 The block SHALL have parameter KER_AW, default 9, meaning kernel memory address width per bank (512 entries).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; latches counts and begins a layer.
REQ-006 image_count  input  IMG_AW+1  number of image FFT tiles to store, 0..2^IMG_AW.
REQ-007 kernel_count  input  KER_AW+1  number of kernel FFT tiles per bank, 0..2^KER_AW.
REQ-008 image_or_filter  input  1  tag of the current FFT result: 0 image, 1 filter.
REQ-009 fft_next_out  input  1  AND of all 2D-FFT next_out flags; FFT data is valid the following cycle.
REQ-010 image_we / image_write_address  output  1 / IMG_AW  image memory write control, shared by all 4 image banks.
REQ-011 kernel_we  output  2  per-bank write enable for kernel banks 0 and 1.
REQ-012 kernel_write_address  output  KER_AW  shared kernel write address.
REQ-013 image_read_address / kernel_read_address  output  IMG_AW / KER_AW  read addresses for the multiply phase.
REQ-014 read_valid  output  1  memory read data valid this cycle.
REQ-015 busy / done / error  output  1 each  layer in progress / one-cycle completion pulse / sticky tag-mismatch flag.

Function
REQ-016 States SHALL be IDLE, WR_IMAGE, WR_KER0, WR_KER1, READ, FINISH.
REQ-017 IDLE -> WR_IMAGE on start; counts latched that cycle; all addresses cleared; start while busy SHALL be ignored.
REQ-018 Write strobe: image_we or kernel_we[b] SHALL assert exactly one cycle after an accepted fft_next_out; the address presented is the current write count; the count increments after that strobe.
REQ-019 In WR_IMAGE, fft_next_out is accepted only with image_or_filter=0; in WR_KER0/WR_KER1 only with image_or_filter=1.
REQ-020 A fft_next_out with a mismatched tag, or received in IDLE/READ/FINISH, SHALL produce no write and SHALL set error until reset.
REQ-021 A write phase SHALL end on the cycle its final strobe is issued (count reaches latched value): WR_IMAGE -> WR_KER0 -> WR_KER1 -> READ; a phase with count 0 SHALL be skipped in one cycle.
REQ-022 Back-to-back fft_next_out on consecutive cycles SHALL produce consecutive strobes with no loss, including across a phase boundary.
REQ-023 READ: outer loop kernel_read_address 0..kernel_count-1, inner loop image_read_address 0..image_count-1, one address pair per cycle, no bubbles.
REQ-024 read_valid SHALL assert one cycle after each address pair is issued (1-cycle memory latency).
REQ-025 If image_count or kernel_count is 0, READ SHALL issue no addresses.
REQ-026 FINISH SHALL last one cycle after the last read_valid, pulse done, return to IDLE.
REQ-027 Address counters SHALL not wrap: a count of 2^AW ends at address 2^AW-1.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 reset SHALL force IDLE and drive every output to 0, including error, and discard in-flight strobes, regardless of state.
REQ-030 start asserted with reset SHALL be ignored.

Structure
REQ-031 State enum and default widths SHALL live in the shared conv layer package.
REQ-032 One sub-module, addr_counter (load, enable, terminal-count flag), SHALL be instantiated for each write and read address counter.

Verification
REQ-033 image_count=3, kernel_count=2, start; 3 image + 4 filter fft_next_out pulses -> image_we at addresses 0,1,2; kernel_we[0] at 0,1; kernel_we[1] at 0,1; 6 read pairs; done one cycle after the last read_valid.
REQ-034 Filter-tagged pulse during WR_IMAGE -> no write, error=1, image_write_address unchanged.
REQ-035 image_count=4 with fft_next_out every cycle -> image_we high for 4 consecutive cycles, addresses 0..3, next pulse lands in kernel bank 0 at address 0.
REQ-036 kernel_count=0 -> WR_KER0/WR_KER1 skipped, no reads, done pulses.
REQ-037 reset during READ at address pair (1,2) -> next cycle IDLE, all outputs 0; new start runs cleanly.
REQ-038 image_count=8192 -> final image_we at address 8191, no wrap to 0.
